// File: rtl/aha_half_freq_reset_seq.sv
`default_nettype none
// ============================================================================
//  Module   : aha_half_freq_reset_seq
//  Purpose  : Reset sequencer for a divide-by-2 clock generator. It holds
//             the generator in reset, releases it, waits an even number of
//             fast-clock edges, and then releases the divided-clock domain.
//             It also runs the same sequence for a software reset request
//             that uses a 4-phase REQ/ACK handshake.
//  Revision : 1.0 - initial release
// ============================================================================
module aha_half_freq_reset_seq #(
  parameter int ASSERT_CYCLES     = 8,
  parameter int DIV_SETTLE_CYCLES = 4,
  parameter int CNT_W             = 8
) (
  input  logic CLK_IN,
  input  logic RESET,
  input  logic SW_RST_REQ,
  output logic SW_RST_ACK,
  output logic DIV_RESETn,
  output logic SYS_RESETn,
  output logic SEQ_BUSY
);

  // Terminal counts for the two timed phases. The counter restarts at zero
  // on every state change, so each phase lasts exactly its cycle count.
  localparam logic [CNT_W-1:0] ASSERT_LAST = CNT_W'(ASSERT_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(DIV_SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_ASSERT   = 2'd0,
    ST_DIV_WAIT = 2'd1,
    ST_RUN      = 2'd2,
    ST_ACK_WAIT = 2'd3
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  // Remembers that the running sequence was started by software, so the
  // requester gets its ACK when the sequence finishes.
  logic             pending;

  // Sequencer FSM. Every output is assigned together with the state it
  // belongs to, so outputs change on the same edge as the state.
  always_ff @(posedge CLK_IN) begin
    if (RESET) begin
      state      <= ST_ASSERT;
      cnt        <= '0;
      pending    <= 1'b0;
      DIV_RESETn <= 1'b0;
      SYS_RESETn <= 1'b0;
      SW_RST_ACK <= 1'b0;
      SEQ_BUSY   <= 1'b1;
    end else begin
      case (state)
        ST_ASSERT: begin
          if (cnt == ASSERT_LAST) begin
            state      <= ST_DIV_WAIT;
            cnt        <= '0;
            DIV_RESETn <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        ST_DIV_WAIT: begin
          // An even settle time leaves the divided clock low and about to
          // rise at the moment the divided-clock domain leaves reset.
          if (cnt == SETTLE_LAST) begin
            cnt        <= '0;
            SYS_RESETn <= 1'b1;
            SEQ_BUSY   <= 1'b0;
            if (pending) begin
              state      <= ST_ACK_WAIT;
              pending    <= 1'b0;
              SW_RST_ACK <= 1'b1;
            end else begin
              state <= ST_RUN;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        ST_RUN: begin
          // New software requests are only accepted here; both resets drop
          // on the same edge that samples the request.
          if (SW_RST_REQ) begin
            state      <= ST_ASSERT;
            cnt        <= '0;
            pending    <= 1'b1;
            DIV_RESETn <= 1'b0;
            SYS_RESETn <= 1'b0;
            SEQ_BUSY   <= 1'b1;
          end
        end

        ST_ACK_WAIT: begin
          // Finish the 4-phase handshake once the requester drops REQ.
          if (!SW_RST_REQ) begin
            state      <= ST_RUN;
            cnt        <= '0;
            SW_RST_ACK <= 1'b0;
          end
        end

        default: begin
          state      <= ST_ASSERT;
          cnt        <= '0;
          pending    <= 1'b0;
          DIV_RESETn <= 1'b0;
          SYS_RESETn <= 1'b0;
          SW_RST_ACK <= 1'b0;
          SEQ_BUSY   <= 1'b1;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_aha_half_freq_reset_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_aha_half_freq_reset_seq
//  Purpose  : Self-checking bench for aha_half_freq_reset_seq with a
//             divide-by-2 generator attached to DIV_RESETn.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_aha_half_freq_reset_seq;

  localparam int A    = 8;
  localparam int S    = 4;
  localparam int DONE = A + S;

  logic clk;
  logic rst;
  logic req;
  logic ack;
  logic div_rstn;
  logic sys_rstn;
  logic busy;
  logic div_clk;

  int tests;
  int failed;

  typedef struct {
    logic [4:0] exp;
    logic [4:0] care;
  } exp_t;

  exp_t sb[$];

  aha_half_freq_reset_seq #(
    .ASSERT_CYCLES    (A),
    .DIV_SETTLE_CYCLES(S),
    .CNT_W            (8)
  ) dut (
    .CLK_IN    (clk),
    .RESET     (rst),
    .SW_RST_REQ(req),
    .SW_RST_ACK(ack),
    .DIV_RESETn(div_rstn),
    .SYS_RESETn(sys_rstn),
    .SEQ_BUSY  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Divide-by-2 generator fed by the sequencer, on the same fast clock.
  always_ff @(posedge clk) begin
    if (!div_rstn) div_clk <= 1'b0;
    else           div_clk <= ~div_clk;
  end

  // Expected {DIV_RESETn, SYS_RESETn, ACK, BUSY, div_clk} after edge e of a
  // sequence (e = 0 is the edge that starts it / last RESET edge).
  function automatic logic [4:0] exp_vec(int e, logic a);
    logic d, s, k;
    d = (e >= A);
    s = (e >= DONE);
    k = (e > A) ? logic'((e - A) % 2) : 1'b0;
    return {d, s, a, ~s, k};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive inputs for the next edge, push the expected result, advance.
  task automatic drive(input logic r, input logic q, input logic [4:0] e,
                       input logic [4:0] c);
    exp_t it;
    rst = r;
    req = q;
    it.exp  = e;
    it.care = c;
    sb.push_back(it);
    tick();
  endtask

  function automatic logic [4:0] observed();
    return {div_rstn, sys_rstn, ack, busy, div_clk};
  endfunction

  task automatic test_reset();
    exp_t it;
    logic [4:0] obs;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 5'b00010, (i == 0) ? 5'b11110 : 5'b11111);
      it = sb.pop_front(); obs = observed(); tests++;
      if ((obs & it.care) !== (it.exp & it.care)) begin
        failed++;
        $display("FAIL reset_hold cyc %0d: got %b expected %b", i, obs, it.exp);
      end
    end
    for (int e = 1; e <= 20; e++) begin
      drive(1'b0, 1'b0, exp_vec(e, 1'b0), 5'b11111);
      it = sb.pop_front(); obs = observed(); tests++;
      if ((obs & it.care) !== (it.exp & it.care)) begin
        failed++;
        $display("FAIL reset_release edge %0d: got %b expected %b", e, obs, it.exp);
      end
    end
  endtask

  task automatic test_sw_req_held();
    exp_t it;
    logic [4:0] obs;
    for (int e = 0; e <= 18; e++) begin
      drive(1'b0, e <= 15, exp_vec(e, (e >= DONE) && (e <= 15)),
            (e == 0) ? 5'b11110 : 5'b11111);
      it = sb.pop_front(); obs = observed(); tests++;
      if ((obs & it.care) !== (it.exp & it.care)) begin
        failed++;
        $display("FAIL sw_req_held edge %0d: got %b expected %b", e, obs, it.exp);
      end
    end
  endtask

  task automatic test_sw_req_pulse();
    exp_t it;
    logic [4:0] obs;
    for (int e = 0; e <= 15; e++) begin
      drive(1'b0, e == 0, exp_vec(e, e == DONE), (e == 0) ? 5'b11110 : 5'b11111);
      it = sb.pop_front(); obs = observed(); tests++;
      if ((obs & it.care) !== (it.exp & it.care)) begin
        failed++;
        $display("FAIL sw_req_pulse edge %0d: got %b expected %b", e, obs, it.exp);
      end
    end
  endtask

  task automatic test_reset_mid_seq();
    exp_t it;
    logic [4:0] obs;
    logic [4:0] v;
    // Software sequence up to DIV_WAIT with cnt=2 (after edge 10).
    for (int e = 0; e <= 10; e++) begin
      drive(1'b0, e == 0, exp_vec(e, 1'b0), (e == 0) ? 5'b11110 : 5'b11111);
      it = sb.pop_front(); obs = observed(); tests++;
      if ((obs & it.care) !== (it.exp & it.care)) begin
        failed++;
        $display("FAIL mid_seq_pre edge %0d: got %b expected %b", e, obs, it.exp);
      end
    end
    v = exp_vec(11, 1'b0);
    drive(1'b1, 1'b0, {4'b0001, v[0]}, 5'b11111);
    it = sb.pop_front(); obs = observed(); tests++;
    if ((obs & it.care) !== (it.exp & it.care)) begin
      failed++;
      $display("FAIL mid_seq_reset: got %b expected %b", obs, it.exp);
    end
    for (int r = 1; r <= 20; r++) begin
      drive(1'b0, 1'b0, exp_vec(r, 1'b0), 5'b11111);
      it = sb.pop_front(); obs = observed(); tests++;
      if ((obs & it.care) !== (it.exp & it.care)) begin
        failed++;
        $display("FAIL mid_seq_restart edge %0d: got %b expected %b", r, obs, it.exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t it;
    logic [4:0] obs;
    // REQ held through ACK_WAIT, dropped for exactly one cycle.
    for (int e = 0; e <= 14; e++) begin
      drive(1'b0, e != 14, exp_vec(e, (e == 12) || (e == 13)),
            (e == 0) ? 5'b11110 : 5'b11111);
      it = sb.pop_front(); obs = observed(); tests++;
      if ((obs & it.care) !== (it.exp & it.care)) begin
        failed++;
        $display("FAIL b2b_first edge %0d: got %b expected %b", e, obs, it.exp);
      end
    end
    // Raised again after one RUN cycle: a second full sequence.
    for (int e = 0; e <= 14; e++) begin
      drive(1'b0, e <= 12, exp_vec(e, e == DONE), (e == 0) ? 5'b11110 : 5'b11111);
      it = sb.pop_front(); obs = observed(); tests++;
      if ((obs & it.care) !== (it.exp & it.care)) begin
        failed++;
        $display("FAIL b2b_second edge %0d: got %b expected %b", e, obs, it.exp);
      end
    end
  endtask

  task automatic test_div_clock();
    exp_t it;
    logic [4:0] obs;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b0, 5'b00010, (i == 0) ? 5'b01000 : 5'b01001);
      it = sb.pop_front(); obs = observed(); tests++;
      if ((obs & it.care) !== (it.exp & it.care)) begin
        failed++;
        $display("FAIL div_clk_reset cyc %0d: got %b expected %b", i, obs, it.exp);
      end
    end
    for (int e = 1; e <= 16; e++) begin
      drive(1'b0, 1'b0, exp_vec(e, 1'b0), 5'b01001);
      it = sb.pop_front(); obs = observed(); tests++;
      if ((obs & it.care) !== (it.exp & it.care)) begin
        failed++;
        $display("FAIL div_clk_run edge %0d: got %b expected %b", e, obs, it.exp);
      end
    end
  endtask

  initial begin
    tests  = 0;
    failed = 0;
    rst    = 1'b1;
    req    = 1'b0;
    test_reset();
    test_sw_req_held();
    test_sw_req_pulse();
    test_reset_mid_seq();
    test_back_to_back();
    test_div_clock();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
`default_nettype wire
